// File: rtl/systolic_array_os.sv
// ---------------------------------------------------------------------------
// systolic_array_os
// N x N output-stationary systolic matrix-multiply engine, C = A x B, where
// A is N x K and B is K x N with K supplied per job. The engine skews its own
// operands, clears its accumulators at job start, flushes the array and then
// emits the result one row per handshake.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start, k_len      job launch pulse (honoured in IDLE only) and inner dim K
//   in_valid/in_ready operand beat handshake; a_col = column k of A,
//                     b_row = row k of B, lane i at [i*DATA_W +: DATA_W]
//   out_valid/out_ready result row handshake; out_row = row index r,
//                     out_data = C[r][0..N-1], lane j at [j*ACC_W +: ACC_W]
//   busy              high whenever the engine is not IDLE
//
// Build option: define SYSTOLIC_ACC_SAT_EN for sticky signed saturation of
// every accumulator; otherwise accumulation wraps modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module systolic_array_os #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 32,
    parameter int N      = 4,
    parameter int K_MAX  = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [$clog2(K_MAX+1)-1:0] k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N*DATA_W-1:0]        a_col,
    input  logic [N*DATA_W-1:0]        b_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(N)-1:0]       out_row,
    output logic [N*ACC_W-1:0]         out_data,
    output logic                       busy
);
    localparam int KW = $clog2(K_MAX+1);
    localparam int RW = $clog2(N);
    localparam int FW = $clog2(2*N);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUT} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] kLen_q, kLen_d;
    logic [KW-1:0] beatCnt_q, beatCnt_d;
    logic [FW-1:0] flushCnt_q, flushCnt_d;
    logic [RW-1:0] row_q, row_d;

    logic accept;
    logic advance;
    logic clearArray;

    // aHop[i][j] / bHop[i][j] are the operands arriving at PE(i,j) this cycle
    logic signed [DATA_W-1:0] aHop    [N][N];
    logic signed [DATA_W-1:0] bHop    [N][N];
    logic signed [ACC_W-1:0]  accGrid [N][N];

    assign accept     = (state_q == LOAD) && in_valid;
    assign advance    = (state_q == LOAD) || (state_q == FLUSH);
    assign clearArray = (state_q == IDLE) && start;

    assign in_ready  = (state_q == LOAD);
    assign out_valid = (state_q == OUT);
    assign busy      = (state_q != IDLE);
    assign out_row   = row_q;

    // State and job counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            kLen_q     <= '0;
            beatCnt_q  <= '0;
            flushCnt_q <= '0;
            row_q      <= '0;
        end else begin
            state_q    <= state_d;
            kLen_q     <= kLen_d;
            beatCnt_q  <= beatCnt_d;
            flushCnt_q <= flushCnt_d;
            row_q      <= row_d;
        end
    end

    // Next-state logic; K=0 jumps straight to FLUSH so the result stays zero
    always_comb begin
        state_d    = state_q;
        kLen_d     = kLen_q;
        beatCnt_d  = beatCnt_q;
        flushCnt_d = flushCnt_q;
        row_d      = row_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    kLen_d     = k_len;
                    beatCnt_d  = '0;
                    flushCnt_d = '0;
                    row_d      = '0;
                    state_d    = (k_len == '0) ? FLUSH : LOAD;
                end
            end
            LOAD: begin
                if (accept) begin
                    beatCnt_d = beatCnt_q + KW'(1);
                    if (beatCnt_q + KW'(1) == kLen_q) begin
                        state_d    = FLUSH;
                        flushCnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                // 2N-1 cycles lets the last beat reach PE(N-1,N-1)
                if (flushCnt_q == FW'(2*N-2)) begin
                    state_d = OUT;
                    row_d   = '0;
                end else begin
                    flushCnt_d = flushCnt_q + FW'(1);
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (row_q == RW'(N-1)) begin
                        state_d = IDLE;
                        row_d   = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result row mux; accumulators are frozen in OUT so the row stays stable
    always_comb begin
        out_data = '0;
        if (state_q == OUT) begin
            for (int j = 0; j < N; j++) begin
                out_data[j*ACC_W +: ACC_W] = accGrid[row_q][j];
            end
        end
    end

    // Input skew: lane i is delayed i cycles; idle cycles inject zeros
    for (genvar i = 0; i < N; i++) begin : gSkew
        logic signed [DATA_W-1:0] aIn;
        logic signed [DATA_W-1:0] bIn;
        assign aIn = accept ? a_col[i*DATA_W +: DATA_W] : '0;
        assign bIn = accept ? b_row[i*DATA_W +: DATA_W] : '0;
        if (i == 0) begin : gDirect
            assign aHop[0][0] = aIn;
            assign bHop[0][0] = bIn;
        end else begin : gDelay
            logic signed [DATA_W-1:0] aDly_q [i];
            logic signed [DATA_W-1:0] bDly_q [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int d = 0; d < i; d++) begin
                        aDly_q[d] <= '0;
                        bDly_q[d] <= '0;
                    end
                end else if (clearArray) begin
                    for (int d = 0; d < i; d++) begin
                        aDly_q[d] <= '0;
                        bDly_q[d] <= '0;
                    end
                end else if (advance) begin
                    aDly_q[0] <= aIn;
                    bDly_q[0] <= bIn;
                    for (int d = 1; d < i; d++) begin
                        aDly_q[d] <= aDly_q[d-1];
                        bDly_q[d] <= bDly_q[d-1];
                    end
                end
            end
            assign aHop[i][0] = aDly_q[i-1];
            assign bHop[0][i] = bDly_q[i-1];
        end
    end

    // Processing elements
    for (genvar i = 0; i < N; i++) begin : gRow
        for (genvar j = 0; j < N; j++) begin : gCol
            logic signed [2*DATA_W-1:0] prod;
            logic signed [ACC_W-1:0]    prodExt;
            logic signed [ACC_W-1:0]    acc_q;
            logic signed [ACC_W-1:0]    acc_d;

            assign prod    = (2*DATA_W)'(aHop[i][j]) * (2*DATA_W)'(bHop[i][j]);
            assign prodExt = ACC_W'(prod);

`ifdef SYSTOLIC_ACC_SAT_EN
            logic                    sat_q;
            logic                    sat_d;
            logic signed [ACC_W:0]   sum;

            // One guard bit exposes overflow; a saturated PE stays pinned
            assign sum = {acc_q[ACC_W-1], acc_q} + {prodExt[ACC_W-1], prodExt};

            always_comb begin
                acc_d = acc_q;
                sat_d = sat_q;
                if (!sat_q) begin
                    if (sum[ACC_W] != sum[ACC_W-1]) begin
                        sat_d = 1'b1;
                        acc_d = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                           : {1'b0, {(ACC_W-1){1'b1}}};
                    end else begin
                        acc_d = sum[ACC_W-1:0];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sat_q <= 1'b0;
                end else if (clearArray) begin
                    sat_q <= 1'b0;
                end else if (advance) begin
                    sat_q <= sat_d;
                end
            end
`else
            assign acc_d = acc_q + prodExt;
`endif

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc_q <= '0;
                end else if (clearArray) begin
                    acc_q <= '0;
                end else if (advance) begin
                    acc_q <= acc_d;
                end
            end

            assign accGrid[i][j] = acc_q;

            if (j < N-1) begin : gPassA
                logic signed [DATA_W-1:0] aPass_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        aPass_q <= '0;
                    end else if (clearArray) begin
                        aPass_q <= '0;
                    end else if (advance) begin
                        aPass_q <= aHop[i][j];
                    end
                end
                assign aHop[i][j+1] = aPass_q;
            end

            if (i < N-1) begin : gPassB
                logic signed [DATA_W-1:0] bPass_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        bPass_q <= '0;
                    end else if (clearArray) begin
                        bPass_q <= '0;
                    end else if (advance) begin
                        bPass_q <= bHop[i][j];
                    end
                end
                assign bHop[i+1][j] = bPass_q;
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_os.sv
// ---------------------------------------------------------------------------
// tb_systolic_array_os
// Self-checking bench for systolic_array_os (N=4, DATA_W=16, ACC_W=32).
// Expected result rows are queued when a job is launched and compared by a
// monitor on every out_valid && out_ready handshake. Uniform-operand jobs
// come from a vector table; identity, backpressure, start-while-busy and
// mid-job reset are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_systolic_array_os;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int N      = 4;
    localparam int K_MAX  = 255;
    localparam int KW     = $clog2(K_MAX+1);
    localparam int RW     = $clog2(N);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [KW-1:0]       k_len = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [N*DATA_W-1:0] a_col = '0;
    logic [N*DATA_W-1:0] b_row = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [RW-1:0]       out_row;
    logic [N*ACC_W-1:0]  out_data;
    logic                busy;

    int errors = 0;
    int checks = 0;
    int cycCnt = 0;

    int aM [N][K_MAX+1];
    int bM [K_MAX+1][N];

    typedef struct {
        int                 row;
        logic [N*ACC_W-1:0] data;
    } rowExp_t;

    typedef struct {
        int               k;
        int               aVal;
        int               bVal;
        int               mode;
        logic [ACC_W-1:0] expElem;
    } vec_t;

    rowExp_t expQ [$];
    rowExp_t monExp;
    vec_t    vecs [5];

    systolic_array_os #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .N     (N),
        .K_MAX (K_MAX)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_col    (a_col),
        .b_row    (b_row),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_row  (out_row),
        .out_data (out_data),
        .busy     (busy)
    );

    // Free-running clock and cycle counter used for latency measurement
    always #5 clk = ~clk;

    always @(posedge clk) cycCnt <= cycCnt + 1;

    task automatic checkOutput(input string name, input logic [N*ACC_W-1:0] act,
                               input logic [N*ACC_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: pop the oldest expected row on each accepted row
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected row: got row %0d, expected none", out_row);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("out_row", {{(N*ACC_W-RW){1'b0}}, out_row}, monExp.row);
                checkOutput($sformatf("row%0d data", monExp.row), out_data, monExp.data);
            end
        end
    end

    task automatic fillUniform(input int aVal, input int bVal);
        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk <= K_MAX; kk++) begin
                aM[i][kk] = aVal;
                bM[kk][i] = bVal;
            end
        end
    endtask

    task automatic pushUniform(input logic [ACC_W-1:0] elem);
        rowExp_t r;
        for (int rr = 0; rr < N; rr++) begin
            r.row = rr;
            for (int j = 0; j < N; j++) r.data[j*ACC_W +: ACC_W] = elem;
            expQ.push_back(r);
        end
    endtask

    // A = identity, B[k][j] = 10k + j, so C must equal B
    task automatic fillIdentity();
        for (int i = 0; i < N; i++) begin
            for (int kk = 0; kk < N; kk++) begin
                aM[i][kk] = (i == kk) ? 1 : 0;
                bM[kk][i] = 10*kk + i;
            end
        end
    endtask

    function automatic logic [N*ACC_W-1:0] identityRow(input int r);
        logic [N*ACC_W-1:0] d;
        for (int j = 0; j < N; j++) d[j*ACC_W +: ACC_W] = ACC_W'(10*r + j);
        return d;
    endfunction

    task automatic pushIdentity();
        rowExp_t r;
        for (int rr = 0; rr < N; rr++) begin
            r.row  = rr;
            r.data = identityRow(rr);
            expQ.push_back(r);
        end
    endtask

    task automatic pulseStart(input int k);
        @(posedge clk); #1;
        start = 1'b1;
        k_len = KW'(k);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive K beats; mode 0 = always valid, 1 = toggling, 2 = random valid
    task automatic applyStimulus(input int k, input int mode, input bit pokeStart,
                                 output int beats, output int beatCyc);
        int budget = 0;
        int cyc = 0;
        bit acc;
        beats   = 0;
        beatCyc = 0;
        while (beats < k && budget < 4000) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (cyc % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            start = pokeStart && (cyc == 0);
            if (start) k_len = KW'(7);
            for (int i = 0; i < N; i++) begin
                a_col[i*DATA_W +: DATA_W] = DATA_W'(aM[i][beats]);
                b_row[i*DATA_W +: DATA_W] = DATA_W'(bM[beats][i]);
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) beatCyc = cycCnt;
            @(posedge clk); #1;
            if (acc) beats++;
            cyc++;
            budget++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        a_col    = '0;
        b_row    = '0;
    endtask

    // Drain the job: latency, in_ready low after loading, optional start poke
    // in OUT and optional 5-cycle stall on row 1
    task automatic finishJob(input int k, input int beatCyc, input bit pokeStart,
                             input bit backpress, input logic [N*ACC_W-1:0] row1);
        int budget = 0;
        bit seen = 0;
        bit rdyLate = 0;
        bit poked = 0;
        bit bpDone = 0;
        out_ready = 1'b1;
        while (busy && budget < 3000) begin
            @(negedge clk);
            if (!out_valid && in_ready) rdyLate = 1'b1;
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (k > 0) checkOutput("latency", cycCnt - beatCyc, 2*N);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (pokeStart && out_valid && !poked) begin
                start = 1'b1;
                k_len = KW'(5);
                poked = 1'b1;
            end
            if (backpress && out_valid && out_row == RW'(1) && !bpDone) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    checkOutput("stall out_row", {{(N*ACC_W-RW){1'b0}}, out_row}, 1);
                    checkOutput("stall out_data", out_data, row1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
                bpDone    = 1'b1;
            end
            budget++;
        end
        start = 1'b0;
        checkOutput("busy cleared", busy, 0);
        checkOutput("rows pending", expQ.size(), 0);
        checkOutput("in_ready after load", rdyLate, 0);
        checkOutput("out_valid seen", seen, 1);
    endtask

    task automatic runUniform(input int k, input int aVal, input int bVal, input int mode,
                              input logic [ACC_W-1:0] elem, input string name);
        int beats;
        int beatCyc;
        fillUniform(aVal, bVal);
        pushUniform(elem);
        pulseStart(k);
        applyStimulus(k, mode, 1'b0, beats, beatCyc);
        checkOutput({name, " beats"}, beats, k);
        finishJob(k, beatCyc, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int beats;
        int beatCyc;

        vecs[0] = '{k:3,   aVal:-2,     bVal:3,      mode:1, expElem:ACC_W'(-18)};
        vecs[1] = '{k:0,   aVal:9,      bVal:9,      mode:0, expElem:ACC_W'(0)};
        vecs[2] = '{k:2,   aVal:7,      bVal:-4,     mode:0, expElem:ACC_W'(-56)};
`ifdef SYSTOLIC_ACC_SAT_EN
        vecs[3] = '{k:255, aVal:-32768, bVal:-32768, mode:0, expElem:32'h7FFF_FFFF};
`else
        vecs[3] = '{k:255, aVal:-32768, bVal:-32768, mode:0, expElem:32'hC000_0000};
`endif
        vecs[4] = '{k:5,   aVal:-300,   bVal:-1000,  mode:2, expElem:ACC_W'(1500000)};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset in_ready", in_ready, 0);
        checkOutput("reset out_row", {{(N*ACC_W-RW){1'b0}}, out_row}, 0);
        checkOutput("reset out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Identity job
        $display("[TB] identity job");
        fillIdentity();
        pushIdentity();
        pulseStart(4);
        applyStimulus(4, 0, 1'b0, beats, beatCyc);
        checkOutput("identity beats", beats, 4);
        finishJob(4, beatCyc, 1'b0, 1'b0, '0);

        // Table-driven uniform jobs
        for (int v = 0; v < 5; v++) begin
            $display("[TB] vector %0d k=%0d", v, vecs[v].k);
            runUniform(vecs[v].k, vecs[v].aVal, vecs[v].bVal, vecs[v].mode,
                       vecs[v].expElem, $sformatf("vec%0d", v));
        end

        // Output backpressure on row 1
        $display("[TB] backpressure job");
        fillIdentity();
        pushIdentity();
        pulseStart(4);
        applyStimulus(4, 0, 1'b0, beats, beatCyc);
        finishJob(4, beatCyc, 1'b0, 1'b1, identityRow(1));

        // start pulsed in LOAD and OUT must be ignored
        $display("[TB] start while busy");
        fillUniform(1, 1);
        pushUniform(ACC_W'(2));
        pulseStart(2);
        applyStimulus(2, 0, 1'b1, beats, beatCyc);
        checkOutput("poke beats", beats, 2);
        finishJob(2, beatCyc, 1'b1, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("start in OUT ignored", busy, 0);
        runUniform(1, 3, 4, 0, ACC_W'(12), "after poke");

        // Reset asserted during FLUSH aborts the job
        $display("[TB] reset mid-job");
        fillUniform(1, 1);
        pulseStart(4);
        applyStimulus(4, 0, 1'b0, beats, beatCyc);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pre-reset busy", busy, 1);
        rst = 1'b0;
        #1;
        checkOutput("abort out_valid", out_valid, 0);
        checkOutput("abort busy", busy, 0);
        checkOutput("abort in_ready", in_ready, 0);
        checkOutput("abort out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        runUniform(1, 1, 5, 0, ACC_W'(5), "post-reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Backstop in case a handshake never completes
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/systolic_array_os.md
Name: systolic_array_os

Overview:
- Parametrised N x N output-stationary systolic matrix-multiply engine computing C = A x B.
- A is N x K, B is K x N, K chosen at run time.
- Owns its own input skew, per-PE accumulator clear, flush and row-wise result readout.
- Sits between the operand buffers and the result writeback path.

Parameters:
- DATA_W, 16, operand width; signed two's complement.
- ACC_W, 32, accumulator/result width; must be >= 2*DATA_W.
- N, 4, array dimension (rows = cols = N); N >= 2.
- K_MAX, 255, largest supported inner dimension.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-low.
- start  input  1  one-cycle pulse; begins a job; sampled only in IDLE.
- k_len  input  $clog2(K_MAX+1)  inner dimension K; captured with start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  engine accepts a beat.
- a_col  input  N*DATA_W  column k of A; lane i = A[i][k] at bits [i*DATA_W +: DATA_W].
- b_row  input  N*DATA_W  row k of B; lane j = B[k][j].
- out_valid  output  1  result row valid.
- out_ready  input  1  downstream accepts the result row.
- out_row  output  $clog2(N)  row index r of the current result.
- out_data  output  N*ACC_W  C[r][0..N-1]; lane j at bits [j*ACC_W +: ACC_W].
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all accumulators, skew registers and pass registers cleared.
- Reset asserted mid-job aborts the job immediately; no partial results are emitted.
- FSM states: IDLE, LOAD, FLUSH, OUT.
- IDLE:
  - start=1 captures k_len, clears all N*N accumulators and the beat counter, then moves to LOAD.
  - start in any other state is ignored.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready; the beat counter increments on each accepted beat.
  - After beat k_len is accepted, the FSM moves to FLUSH on the next cycle.
  - k_len=0 skips LOAD and goes straight to FLUSH; the result is all zeros.
- Array timing:
  - The array advances every cycle in LOAD and FLUSH.
  - Cycles without an accepted beat inject zeros into every lane, so bubbles never misalign operands.
- Skew:
  - a lane i is delayed i cycles before entering PE(i,0).
  - b lane j is delayed j cycles before entering PE(0,j).
- PE behaviour:
  - Multiplies the operands arriving from left and top, then adds to its accumulator.
  - Forwards a rightward and b downward through one register each.
- FLUSH lasts exactly 2N-1 cycles, in_ready=0, then the FSM moves to OUT with out_row=0.
- OUT:
  - out_valid=1; out_data and out_row are held stable while out_ready=0.
  - On out_valid && out_ready, out_row increments.
  - After row N-1 is accepted: out_valid=0, FSM returns to IDLE.
  - start is usable in the cycle after the return to IDLE.
- Arithmetic:
  - Product is signed DATA_W x DATA_W giving 2*DATA_W, sign-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W unless the optional feature below is compiled in.
- Latency from the last accepted beat to the first out_valid is 2N cycles.

Optional Feature:
- Macro: SYSTOLIC_ACC_SAT_EN.
- Defined: every accumulate saturates to the signed ACC_W range [-2^(ACC_W-1), 2^(ACC_W-1)-1]; once saturated, a value stays clamped until the next start.
- Undefined: two's-complement wrap, no saturation logic synthesised.

Test Plan:
- Identity check (N=4, K=4): A = identity, B[k][j] = 10*k + j, in_valid always 1 -> C equals B, rows 0..3 in order; first out_valid 8 cycles after the last beat.
- Negative operands with bubbles (K=3): all A = -2, all B = 3, in_valid toggled 1-0-1-0-1 -> every C element = -18; in_ready low in FLUSH; number of accepted beats = 3.
- Output backpressure: out_ready held low for 5 cycles on row 1 -> out_data and out_row stable throughout; after release, rows 1, 2, 3 emitted; busy falls after row 3.
- Overflow (DATA_W=16, ACC_W=32, K=255, all operands = -32768):
  - sum = 255 * 2^30; wrap build gives C = 0xC0000000.
  - SYSTOLIC_ACC_SAT_EN build gives C = 0x7FFFFFFF.
- k_len=0 and start while busy: k_len=0 -> four all-zero rows. start pulsed during LOAD and OUT -> ignored; the next job after IDLE starts with cleared accumulators.
- Reset mid-job: rst low during FLUSH -> out_valid, busy and in_ready all 0 immediately; a following job with K=1, A = 1, B = 5 yields all C = 5.
